// File: rtl/viterbi_acs_survivor.sv
// viterbi_acs_survivor: K=7 rate-1/2 hard-decision branch metrics, 64-state ACS and survivor buffer with newest-first playback.
// Define VITERBI_ZERO_TAIL_EN for zero-tail frames, where the traceback start state is forced to 0.
module viterbi_acs_survivor #(
   parameter int              FRAME_LEN = 32,
   parameter int              PM_W      = 8,
   parameter logic [PM_W-1:0] INIT_PM   = 8'd63,
   parameter logic [6:0]      G0        = 7'o133,
   parameter logic [6:0]      G1        = 7'o171
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [1:0]  in_bits,
   output logic        in_ready,
   output logic [63:0] decisions,
   output logic [5:0]  minCost,
   output logic        dataReady
);
   localparam int CW = $clog2(FRAME_LEN);

   typedef enum logic [1:0] {ACC, MIN, PLAY} state_t;
   state_t state, state_nxt;

   logic [CW-1:0]   sym_cnt;
   logic [CW:0]     rd_ptr;
   logic [PM_W-1:0] pm     [64];
   logic [PM_W-1:0] pm_nxt [64];
   logic [PM_W-1:0] pm_min;
   logic [5:0]      pm_arg;
   logic [63:0]     dec;
   logic [63:0]     ram [FRAME_LEN];
   logic            xfer, load_min, play_step, restart, last_sym, play_done;

   function automatic logic [1:0] bm(input logic [6:0] w, input logic [1:0] rx);
      logic [1:0] d;
      d = {^(w & G1), ^(w & G0)} ^ rx;
      return {d[1] & d[0], d[1] ^ d[0]};
   endfunction

   assign last_sym  = sym_cnt == CW'(FRAME_LEN - 1);
   // rd_ptr only goes negative after entry 0 has been presented
   assign play_done = rd_ptr[CW];

   // w = {p, b}: predecessor {0,s[5:1]} gives w = s, predecessor {1,s[5:1]} gives w = s + 64
   for (genvar i = 0; i < 64; i++) begin : g_acs
      logic [PM_W-1:0] c0, c1;
      assign c0        = pm[i/2] + PM_W'(bm(7'(i), in_bits));
      assign c1        = pm[i/2 + 32] + PM_W'(bm(7'(i + 64), in_bits));
      assign dec[i]    = c1 < c0;
      assign pm_nxt[i] = (dec[i] ? c1 : c0) - pm_min;
   end

   always_comb begin
      pm_min = pm[0];
      pm_arg = '0;
      for (int i = 1; i < 64; i++)
         if (pm[i] < pm_min) begin
            pm_min = pm[i];
            pm_arg = 6'(i);
         end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= ACC;
      else     state <= state_nxt;

   always_comb
      state_nxt = (state == ACC) ? ((xfer && last_sym) ? MIN : ACC) :
                  (state == MIN) ? PLAY : (play_done ? ACC : PLAY);

   always_comb begin
      xfer      = (state == ACC) && in_valid && in_ready;
      load_min  = state == MIN;
      play_step = (state == PLAY) && !play_done;
      restart   = (state == PLAY) && play_done;
   end

   always_ff @(posedge clk)
      if (xfer) ram[sym_cnt] <= dec;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         in_ready  <= 1'b0;
         decisions <= '0;
         minCost   <= '0;
         dataReady <= 1'b0;
         sym_cnt   <= '0;
         rd_ptr    <= '0;
         for (int i = 0; i < 64; i++) pm[i] <= (i == 0) ? '0 : INIT_PM;
      end else begin
         in_ready <= state_nxt == ACC;
         if (xfer) begin
            for (int i = 0; i < 64; i++) pm[i] <= pm_nxt[i];
            sym_cnt <= sym_cnt + 1'b1;
         end
         if (load_min) begin
`ifdef VITERBI_ZERO_TAIL_EN
            minCost <= 6'd0;
`else
            minCost <= pm_arg;
`endif
            decisions <= ram[FRAME_LEN-1];
            dataReady <= 1'b1;
            rd_ptr    <= (CW+1)'(FRAME_LEN - 2);
         end
         if (play_step) begin
            decisions <= ram[rd_ptr[CW-1:0]];
            rd_ptr    <= rd_ptr - 1'b1;
         end
         if (restart) begin
            dataReady <= 1'b0;
            sym_cnt   <= '0;
            for (int i = 0; i < 64; i++) pm[i] <= (i == 0) ? '0 : INIT_PM;
         end
      end
endmodule
